// File: rtl/ctrl_pkg.sv
// Shared encodings for the instruction-sequencing controller: FSM states,
// opcode class codes, datapath select constants and ALU operation codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_MEM_WAIT        = 4'd0,
        ST_DECODE          = 4'd1,
        ST_ALU_PROC        = 4'd2,
        ST_INC_QCLK        = 4'd3,
        ST_JUMP_COND       = 4'd4,
        ST_ALU_FPROC_WAIT  = 4'd5,
        ST_JUMP_FPROC_WAIT = 4'd6,
        ST_SYNC_WAIT       = 4'd7,
        ST_DONE            = 4'd8,
        ST_ERROR           = 4'd9
    } state_t;

    localparam logic [3:0] CLS_PULSE_WRITE      = 4'b1000;
    localparam logic [3:0] CLS_PULSE_WRITE_TRIG = 4'b1001;
    localparam logic [3:0] CLS_REG_ALU          = 4'b0001;
    localparam logic [3:0] CLS_JUMP_I           = 4'b0010;
    localparam logic [3:0] CLS_JUMP_COND        = 4'b0011;
    localparam logic [3:0] CLS_ALU_FPROC        = 4'b0100;
    localparam logic [3:0] CLS_JUMP_FPROC       = 4'b0101;
    localparam logic [3:0] CLS_INC_QCLK         = 4'b0110;
    localparam logic [3:0] CLS_SYNC             = 4'b0111;
    localparam logic [3:0] CLS_DONE             = 4'b1010;

    localparam logic [1:0] ALU_IN1_QCLK  = 2'b00;
    localparam logic [1:0] ALU_IN1_REG   = 2'b01;
    localparam logic [1:0] ALU_IN1_FPROC = 2'b10;

    localparam logic [1:0] INSTR_PTR_LOAD_EN_INC = 2'b00;
    localparam logic [1:0] INSTR_PTR_LOAD_EN_IMM = 2'b01;
    localparam logic [1:0] INSTR_PTR_LOAD_EN_ALU = 2'b10;

    localparam logic [2:0] ALU_OP_ID0  = 3'b000;
    localparam logic [2:0] ALU_OP_ADD  = 3'b001;
    localparam logic [2:0] ALU_OP_SUB  = 3'b010;
    localparam logic [2:0] ALU_OP_ID1  = 3'b011;
    localparam logic [2:0] ALU_OP_EQ   = 3'b100;
    localparam logic [2:0] ALU_OP_LE   = 3'b101;
    localparam logic [2:0] ALU_OP_GE   = 3'b110;
    localparam logic [2:0] ALU_OP_ZERO = 3'b111;

    // ALU in1 source implied by an instruction class while it is being decoded.
    function automatic logic [1:0] class_in1_src(input logic [3:0] cls);
        case (cls)
            CLS_REG_ALU, CLS_JUMP_COND:   return ALU_IN1_REG;
            CLS_ALU_FPROC, CLS_JUMP_FPROC: return ALU_IN1_FPROC;
            default:                      return ALU_IN1_QCLK;
        endcase
    endfunction

    function automatic logic is_wait_state(input state_t s);
        return (s == ST_ALU_FPROC_WAIT) || (s == ST_JUMP_FPROC_WAIT) || (s == ST_SYNC_WAIT);
    endfunction

endpackage

// File: rtl/ctrl_wait_ctr.sv
// Clearable up-counter with a terminal-count flag; used for both the memory
// read latency and the bounded fproc/sync waits.
module ctrl_wait_ctr #(
    parameter int          WIDTH    = 4,
    parameter int unsigned TERMINAL = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam logic [WIDTH-1:0] TERM_VAL = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] cnt;

    // Clear has priority so a counter can be restarted on the cycle it terminates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign term = (cnt == TERM_VAL);

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Instruction-sequencing controller: waits out the memory read latency,
// decodes the opcode class and drives every datapath enable of the core.
module proc_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_READ_CYCLES = 3,
    parameter int WAIT_TIMEOUT    = 0,
    parameter int TIMEOUT_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] opcode,
    input  logic       fproc_ready,
    input  logic       sync_enable,
    input  logic       cstrobe_in,
    output logic [2:0] alu_opcode,
    output logic       alu_in0_sel,
    output logic [1:0] alu_in1_sel,
    output logic       reg_write_en,
    output logic       qclk_load_en,
    output logic       write_pulse_en,
    output logic       c_strobe_enable,
    output logic       instr_load_en,
    output logic       instr_ptr_en,
    output logic [1:0] instr_ptr_load_en,
    output logic       fproc_out_ready,
    output logic       sync_out_ready,
    output logic       done_stb,
    output logic       err
);

    localparam int unsigned MEM_TERM  = MEM_READ_CYCLES - 1;
    localparam int unsigned WAIT_TERM = (WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1;
    localparam bit          TIMEOUT_EN = (WAIT_TIMEOUT != 0);

    state_t     state;
    state_t     next_state;
    logic [1:0] in1_src;
    logic [1:0] dec_in1;
    logic [3:0] op_class;
    logic       in_wait;
    logic       mem_clr;
    logic       mem_term;
    logic       wait_clr;
    logic       wait_term;
    logic       timeout_hit;

    assign op_class    = opcode[7:4];
    assign in_wait     = is_wait_state(state);
    assign mem_clr     = (state != ST_MEM_WAIT) || mem_term;
    assign wait_clr    = !in_wait || (next_state != state);
    assign timeout_hit = TIMEOUT_EN && wait_term;

    ctrl_wait_ctr #(
        .WIDTH    (4),
        .TERMINAL (MEM_TERM)
    ) u_mem_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (mem_clr),
        .en    (state == ST_MEM_WAIT),
        .term  (mem_term)
    );

    ctrl_wait_ctr #(
        .WIDTH    (TIMEOUT_W),
        .TERMINAL (WAIT_TERM)
    ) u_wait_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (wait_clr),
        .en    (in_wait),
        .term  (wait_term)
    );

    // in1_src captures the decoded ALU operand source as DECODE is left, so
    // the post-wait ALU/jump cycles keep the fproc path selected.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_MEM_WAIT;
            in1_src <= ALU_IN1_QCLK;
        end else begin
            state <= next_state;
            if (state == ST_DECODE && next_state != ST_DECODE) begin
                in1_src <= dec_in1;
            end
        end
    end

    assign alu_opcode  = opcode[2:0];
    assign alu_in0_sel = reset & opcode[3];

    always_comb begin
        next_state        = state;
        dec_in1           = class_in1_src(op_class);
        alu_in1_sel       = in1_src;
        reg_write_en      = 1'b0;
        qclk_load_en      = 1'b0;
        write_pulse_en    = 1'b0;
        c_strobe_enable   = 1'b0;
        instr_load_en     = 1'b0;
        instr_ptr_en      = 1'b0;
        instr_ptr_load_en = INSTR_PTR_LOAD_EN_INC;
        fproc_out_ready   = 1'b0;
        sync_out_ready    = 1'b0;
        done_stb          = 1'b0;
        err               = 1'b0;

        case (state)
            ST_MEM_WAIT: begin
                if (mem_term) begin
                    instr_load_en = 1'b1;
                    instr_ptr_en  = 1'b1;
                    next_state    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_in1_sel = dec_in1;
                case (op_class)
                    CLS_PULSE_WRITE: begin
                        write_pulse_en = 1'b1;
                        next_state     = ST_MEM_WAIT;
                    end
                    CLS_PULSE_WRITE_TRIG: begin
                        write_pulse_en  = 1'b1;
                        c_strobe_enable = 1'b1;
                        if (cstrobe_in) begin
                            next_state = ST_MEM_WAIT;
                        end
                    end
                    CLS_REG_ALU:   next_state = ST_ALU_PROC;
                    CLS_JUMP_I: begin
                        instr_ptr_load_en = INSTR_PTR_LOAD_EN_IMM;
                        next_state        = ST_MEM_WAIT;
                    end
                    CLS_JUMP_COND: next_state = ST_JUMP_COND;
                    CLS_INC_QCLK:  next_state = ST_INC_QCLK;
                    CLS_ALU_FPROC: begin
                        fproc_out_ready = 1'b1;
                        next_state      = ST_ALU_FPROC_WAIT;
                    end
                    CLS_JUMP_FPROC: begin
                        fproc_out_ready = 1'b1;
                        next_state      = ST_JUMP_FPROC_WAIT;
                    end
                    CLS_SYNC: begin
                        sync_out_ready = 1'b1;
                        next_state     = ST_SYNC_WAIT;
                    end
                    CLS_DONE:      next_state = ST_DONE;
                    default:       next_state = ST_ERROR;
                endcase
            end
            ST_ALU_PROC: begin
                reg_write_en = 1'b1;
                next_state   = ST_MEM_WAIT;
            end
            ST_INC_QCLK: begin
                qclk_load_en = 1'b1;
                next_state   = ST_MEM_WAIT;
            end
            ST_JUMP_COND: begin
                instr_ptr_load_en = INSTR_PTR_LOAD_EN_ALU;
                next_state        = ST_MEM_WAIT;
            end
            // A ready arriving on the terminal wait cycle still wins over the timeout.
            ST_ALU_FPROC_WAIT: begin
                if (fproc_ready) begin
                    next_state = ST_ALU_PROC;
                end else if (timeout_hit) begin
                    next_state = ST_ERROR;
                end
            end
            ST_JUMP_FPROC_WAIT: begin
                if (fproc_ready) begin
                    next_state = ST_JUMP_COND;
                end else if (timeout_hit) begin
                    next_state = ST_ERROR;
                end
            end
            ST_SYNC_WAIT: begin
                if (sync_enable) begin
                    next_state = ST_MEM_WAIT;
                end else if (timeout_hit) begin
                    next_state = ST_ERROR;
                end
            end
            ST_DONE:  done_stb = 1'b1;
            ST_ERROR: err      = 1'b1;
            default:  next_state = ST_ERROR;
        endcase

        // Outputs are forced quiet for the whole time reset is held low.
        if (!reset) begin
            alu_in1_sel       = ALU_IN1_QCLK;
            reg_write_en      = 1'b0;
            qclk_load_en      = 1'b0;
            write_pulse_en    = 1'b0;
            c_strobe_enable   = 1'b0;
            instr_load_en     = 1'b0;
            instr_ptr_en      = 1'b0;
            instr_ptr_load_en = INSTR_PTR_LOAD_EN_INC;
            fproc_out_ready   = 1'b0;
            sync_out_ready    = 1'b0;
            done_stb          = 1'b0;
            err               = 1'b0;
        end
    end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Self-checking bench for proc_ctrl_fsm: directed scenarios followed by a
// randomized instruction stream against an instruction-level timing model.
module tb_proc_ctrl_fsm;

    localparam int M = 3;
    localparam int T = 8;

    localparam logic [3:0] C_PW  = 4'b1000;
    localparam logic [3:0] C_PWT = 4'b1001;
    localparam logic [3:0] C_RA  = 4'b0001;
    localparam logic [3:0] C_JI  = 4'b0010;
    localparam logic [3:0] C_JC  = 4'b0011;
    localparam logic [3:0] C_AF  = 4'b0100;
    localparam logic [3:0] C_JF  = 4'b0101;
    localparam logic [3:0] C_IQ  = 4'b0110;
    localparam logic [3:0] C_SY  = 4'b0111;
    localparam logic [3:0] C_DN  = 4'b1010;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] opcode = 8'h00;
    logic       fproc_ready = 1'b0;
    logic       sync_enable = 1'b0;
    logic       cstrobe_in = 1'b0;
    logic [2:0] alu_opcode;
    logic       alu_in0_sel;
    logic [1:0] alu_in1_sel;
    logic       reg_write_en, qclk_load_en, write_pulse_en, c_strobe_enable;
    logic       instr_load_en, instr_ptr_en;
    logic [1:0] instr_ptr_load_en;
    logic       fproc_out_ready, sync_out_ready, done_stb, err;

    typedef struct packed {
        logic [1:0] in1;
        logic       rwe;
        logic       qle;
        logic       wpe;
        logic       cse;
        logic       ild;
        logic       ipe;
        logic [1:0] iple;
        logic       fro;
        logic       sro;
        logic       done;
        logic       err;
    } obs_t;

    obs_t       obs;
    int         n_checks = 0;
    int         n_pass = 0;
    int         n_fail = 0;
    logic [1:0] last_src = 2'b00;

    proc_ctrl_fsm #(
        .MEM_READ_CYCLES (M),
        .WAIT_TIMEOUT    (T),
        .TIMEOUT_W       (16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .opcode            (opcode),
        .fproc_ready       (fproc_ready),
        .sync_enable       (sync_enable),
        .cstrobe_in        (cstrobe_in),
        .alu_opcode        (alu_opcode),
        .alu_in0_sel       (alu_in0_sel),
        .alu_in1_sel       (alu_in1_sel),
        .reg_write_en      (reg_write_en),
        .qclk_load_en      (qclk_load_en),
        .write_pulse_en    (write_pulse_en),
        .c_strobe_enable   (c_strobe_enable),
        .instr_load_en     (instr_load_en),
        .instr_ptr_en      (instr_ptr_en),
        .instr_ptr_load_en (instr_ptr_load_en),
        .fproc_out_ready   (fproc_out_ready),
        .sync_out_ready    (sync_out_ready),
        .done_stb          (done_stb),
        .err               (err)
    );

    always #5 clk = ~clk;

    assign obs = {alu_in1_sel, reg_write_en, qclk_load_en, write_pulse_en, c_strobe_enable,
                  instr_load_en, instr_ptr_en, instr_ptr_load_en, fproc_out_ready,
                  sync_out_ready, done_stb, err};

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Operand source each class selects while decoding.
    function automatic logic [1:0] model_src(input logic [3:0] cls);
        if (cls == C_RA || cls == C_JC) return 2'b01;
        if (cls == C_AF || cls == C_JF) return 2'b10;
        return 2'b00;
    endfunction

    task automatic check_obs(input string tag, input obs_t exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_alu(input string tag);
        n_checks++;
        assert ({alu_in0_sel, alu_opcode} === opcode[3:0]) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s_alu: observed %h expected %h", tag, {alu_in0_sel, alu_opcode}, opcode[3:0]);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, check at the falling edge.
    task automatic cyc(input logic fr, input logic se, input logic cs, input obs_t exp,
                       input string tag);
        fproc_ready = fr;
        sync_enable = se;
        cstrobe_in  = cs;
        @(negedge clk);
        check_obs(tag, exp);
        check_alu(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic hold_terminal(input int n, input logic is_done);
        obs_t e;
        for (int i = 0; i < n; i++) begin
            opcode = 8'($urandom);
            e      = '0;
            e.in1  = last_src;
            e.done = is_done;
            e.err  = !is_done;
            cyc(rb(), rb(), rb(), e, is_done ? "done_hold" : "err_hold");
        end
    endtask

    // Plays one instruction. k: wait cycle on which ready/enable arrives
    // (outside 1..T means never, negative means abort after -k wait cycles);
    // s: DECODE cycle index on which cstrobe_in rises.
    task automatic do_instr(input logic [7:0] op, input int k, input int s, output bit terminal);
        obs_t       e;
        logic [3:0] cls;
        logic [1:0] src;
        logic       rdy;
        bit         got;
        cls      = op[7:4];
        opcode   = op;
        terminal = 1'b0;
        for (int i = 0; i < M; i++) begin
            e     = '0;
            e.in1 = last_src;
            e.ild = (i == M - 1);
            e.ipe = (i == M - 1);
            cyc(rb(), rb(), rb(), e, "mem_wait");
        end
        src      = model_src(cls);
        e        = '0;
        e.in1    = src;
        last_src = src;
        case (cls)
            C_PW: begin
                e.wpe = 1'b1;
                cyc(rb(), rb(), rb(), e, "pulse_write");
            end
            C_PWT: begin
                e.wpe = 1'b1;
                e.cse = 1'b1;
                for (int i = 0; i <= s; i++) cyc(rb(), rb(), (i == s), e, "pulse_trig");
            end
            C_JI: begin
                e.iple = 2'b01;
                cyc(rb(), rb(), rb(), e, "jump_i");
            end
            C_RA, C_JC, C_IQ: begin
                cyc(rb(), rb(), rb(), e, "decode");
                e      = '0;
                e.in1  = src;
                e.rwe  = (cls == C_RA);
                e.qle  = (cls == C_IQ);
                e.iple = (cls == C_JC) ? 2'b10 : 2'b00;
                cyc(rb(), rb(), rb(), e, "execute");
            end
            C_AF, C_JF, C_SY: begin
                e.fro = (cls != C_SY);
                e.sro = (cls == C_SY);
                cyc(rb(), rb(), rb(), e, "decode_req");
                got = 1'b0;
                for (int j = 1; j <= T; j++) begin
                    rdy   = (k > 0) && (j == k);
                    e     = '0;
                    e.in1 = src;
                    cyc((cls != C_SY) ? rdy : rb(), (cls == C_SY) ? rdy : rb(), rb(), e, "wait");
                    if (k < 0 && j == -k) return;
                    if (rdy) begin
                        got = 1'b1;
                        break;
                    end
                end
                if (!got) begin
                    terminal = 1'b1;
                    hold_terminal(4, 1'b0);
                end else if (cls != C_SY) begin
                    e      = '0;
                    e.in1  = src;
                    e.rwe  = (cls == C_AF);
                    e.iple = (cls == C_JF) ? 2'b10 : 2'b00;
                    cyc(rb(), rb(), rb(), e, "post_fproc");
                end
            end
            C_DN: begin
                cyc(rb(), rb(), rb(), e, "decode_done");
                terminal = 1'b1;
                hold_terminal(5, 1'b1);
            end
            default: begin
                cyc(rb(), rb(), rb(), e, "decode_illegal");
                terminal = 1'b1;
                hold_terminal(3, 1'b0);
            end
        endcase
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must drop before any edge.
    task automatic do_reset();
        #2;
        opcode = 8'h9F;
        reset  = 1'b0;
        #1;
        check_obs("reset_async", '0);
        n_checks++;
        assert (alu_in0_sel === 1'b0) n_pass++;
        else begin
            n_fail++;
            $error("FAIL reset_in0: observed %b expected 0", alu_in0_sel);
        end
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b1;
        last_src = 2'b00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         trm;
        logic [3:0] cls;
        logic [3:0] illegal [6] = '{4'b0000, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
        int         r;

        opcode      = 8'h9F;
        fproc_ready = 1'b1;
        sync_enable = 1'b1;
        cstrobe_in  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_obs("reset_state", '0);
        reset    = 1'b1;
        last_src = 2'b00;

        do_instr(8'h80, 0, 0, trm);
        do_instr(8'h20, 0, 0, trm);
        do_instr(8'h93, 0, 5, trm);
        do_instr(8'h45, 4, 0, trm);
        do_instr(8'h1A, 0, 0, trm);
        do_instr(8'h72, 0, 0, trm);
        do_reset();
        do_instr(8'h70, T, 0, trm);
        do_instr(8'h5C, 3, 0, trm);
        do_instr(8'h36, 0, 0, trm);
        do_instr(8'h61, 0, 0, trm);
        do_instr(8'h4B, T + 1, 0, trm);
        do_reset();
        do_instr(8'hF0, 0, 0, trm);
        do_reset();
        do_instr(8'hA0, 0, 0, trm);
        do_reset();
        do_instr(8'h57, -2, 0, trm);
        do_reset();
        do_instr(8'h80, 0, 0, trm);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 19);
            case (r / 2)
                0: cls = C_PW;
                1: cls = C_PWT;
                2: cls = C_RA;
                3: cls = C_JI;
                4: cls = C_JC;
                5: cls = C_AF;
                6: cls = C_JF;
                7: cls = C_IQ;
                8: cls = C_SY;
                default: cls = (r == 18) ? C_DN : illegal[$urandom_range(0, 5)];
            endcase
            do_instr({cls, 4'($urandom)}, $urandom_range(1, T + 2), $urandom_range(0, 6), trm);
            if (trm) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/proc_ctrl_fsm.md
# proc_ctrl_fsm

Parametrised instruction-sequencing controller for the distributed processor core. Sits between the instruction memory/command buffer and the datapath (ALU, register file, qclk, pulse registers, instruction pointer). It decodes the 8-bit opcode and drives all datapath enables. Compared with the first-generation controller it adds:
- a configurable memory read latency,
- fully implemented SYNC and DONE paths,
- bounded waits on fproc/sync with a sticky error state,
- deterministic handling of unknown opcodes.

## Interface
Parameters:
- MEM_READ_CYCLES, 3: cycles from instr_ptr change to valid opcode; legal range 1..15.
- WAIT_TIMEOUT, 0: maximum cycles spent in an FPROC/SYNC wait state; 0 disables the timeout.
- TIMEOUT_W, 16: width of the wait counter; WAIT_TIMEOUT < 2^TIMEOUT_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  **asynchronous, active-low** reset.
- opcode  in  8  [7:4] instruction class, [3] ALU in0 select, [2:0] ALU op.
- fproc_ready  in  1  fproc result valid.
- sync_enable  in  1  sync barrier released.
- cstrobe_in  in  1  pulse trigger strobe from the qclk comparator.
- alu_opcode  out  3  = opcode[2:0].
- alu_in0_sel  out  1  = opcode[3].
- alu_in1_sel  out  2  00 qclk, 01 reg, 10 fproc.
- reg_write_en, qclk_load_en, write_pulse_en, c_strobe_enable, instr_load_en, instr_ptr_en  out  1 each  datapath enables.
- instr_ptr_load_en  out  2  00 increment path, 01 load immediate, 10 load from ALU result.
- fproc_out_ready, sync_out_ready  out  1 each  request strobes.
- done_stb  out  1  high while in DONE.
- err  out  1  high while in ERROR.

## Operation
- Class codes:
  - 1000 PULSE_WRITE
  - 1001 PULSE_WRITE_TRIG
  - 0001 REG_ALU
  - 0010 JUMP_I
  - 0011 JUMP_COND
  - 0100 ALU_FPROC
  - 0101 JUMP_FPROC
  - 0110 INC_QCLK
  - 0111 SYNC
  - 1010 DONE
  - all others are illegal.
- States: MEM_WAIT, DECODE, ALU_PROC, INC_QCLK, JUMP_COND, ALU_FPROC_WAIT, JUMP_FPROC_WAIT, SYNC_WAIT, DONE, ERROR.
- MEM_WAIT:
  - Counter mem_cnt increments each cycle.
  - When mem_cnt == MEM_READ_CYCLES-1: assert instr_load_en and instr_ptr_en, clear mem_cnt, go to DECODE.
  - mem_cnt is held at 0 in every other state.
- DECODE, per class:
  - PULSE_WRITE: write_pulse_en; go to MEM_WAIT.
  - PULSE_WRITE_TRIG: write_pulse_en and c_strobe_enable; stay in DECODE until cstrobe_in, then go to MEM_WAIT.
  - REG_ALU: in1=reg; go to ALU_PROC.
  - JUMP_I: instr_ptr_load_en=01; go to MEM_WAIT.
  - JUMP_COND: in1=reg; go to JUMP_COND.
  - INC_QCLK: in1=qclk; go to INC_QCLK.
  - ALU_FPROC: fproc_out_ready; go to ALU_FPROC_WAIT.
  - JUMP_FPROC: fproc_out_ready; go to JUMP_FPROC_WAIT.
  - SYNC: sync_out_ready; go to SYNC_WAIT.
  - DONE: go to DONE.
  - Illegal class: go to ERROR.
- ALU_PROC: reg_write_en; go to MEM_WAIT.
- INC_QCLK: qclk_load_en; go to MEM_WAIT.
- JUMP_COND: instr_ptr_load_en=10; go to MEM_WAIT.
- ALU_FPROC_WAIT / JUMP_FPROC_WAIT: on fproc_ready go to ALU_PROC / JUMP_COND respectively.
- SYNC_WAIT: on sync_enable go to MEM_WAIT.
- Wait timeout:
  - wait_cnt increments in every wait state and clears on leaving it.
  - If WAIT_TIMEOUT != 0 and wait_cnt == WAIT_TIMEOUT-1 with no ready/enable, go to ERROR.
  - A ready/enable arriving on that same cycle wins over the timeout.
- alu_in1_sel:
  - In DECODE it is decoded from the opcode.
  - It is latched into in1_src on DECODE exit and driven from in1_src in all later states, so an fproc-sourced ALU_PROC/JUMP_COND keeps 10.
  - in1_src resets to 00.
- DONE and ERROR are terminal; only reset exits them.
- All enables not listed for a state are 0.

## Timing
- Reset low, asynchronously:
  - state=MEM_WAIT, mem_cnt=0, wait_cnt=0, in1_src=00.
  - All 1-bit outputs are 0 and instr_ptr_load_en=00, including instr_load_en/instr_ptr_en.
- First instr_load_en occurs MEM_READ_CYCLES cycles after reset deassertion.
- Outputs are combinational from the registered state, plus opcode in DECODE (for PULSE_WRITE_TRIG, c_strobe_enable only).
- Instruction latency in cycles, including MEM_WAIT:
  - PULSE_WRITE / JUMP_I: M+1
  - REG_ALU / INC_QCLK / JUMP_COND: M+2
  - fproc instructions: M+2+k, where k = wait cycles.
  - SYNC: M+1+k.
- fproc_out_ready and sync_out_ready are single-cycle strobes in DECODE.
- A ready arriving in that DECODE cycle is ignored; the controller samples ready from the first wait-state cycle onward.

## Structure
- Package ctrl_pkg holds:
  - state encoding,
  - 4-bit class codes,
  - ALU_IN1_* and INSTR_PTR_LOAD_EN_* constants,
  - ALU op codes.
- Sub-module ctrl_wait_ctr: a parametrised counter (WIDTH, TERMINAL) with clear/enable and a terminal flag. Instantiate it twice, once for mem_cnt and once for wait_cnt.

## Test plan
- MEM_READ_CYCLES=3, PULSE_WRITE then JUMP_I: instr_load_en pulses at cycles 3 and 7 after reset release; JUMP_I gives instr_ptr_load_en=01 for 1 cycle.
- PULSE_WRITE_TRIG with cstrobe_in raised 5 cycles into DECODE: write_pulse_en and c_strobe_enable stay high 6 cycles, then MEM_WAIT.
- ALU_FPROC, fproc_ready after 4 wait cycles: alu_in1_sel=10 through ALU_PROC; reg_write_en is high for exactly 1 cycle.
- WAIT_TIMEOUT=8, SYNC with sync_enable never high: err rises on wait cycle 8 and stays until reset; sync_enable on cycle 8 instead goes to MEM_WAIT with no err.
- Opcode 8'hF0: err on the cycle after DECODE. Opcode DONE: done_stb high continuously.
- Reset low mid-JUMP_FPROC_WAIT: all outputs 0 immediately (asynchronous); after release, MEM_WAIT restarts from 0.
